// File: rtl/regfile_pkg.sv
// Shared constants, types and helpers for the register-file access controller.
//   NUM_REGS  : number of architectural registers
//   ZERO_REG  : hard-zero register, never pending
//   WR_LAT    : edges from write accept until a read may observe the data
//   RD_LAT    : read latency of the register file (depth of valid pipeline)
//   PEND_W    : width of each per-register pending countdown
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
  localparam int WR_LAT     = 3;
  localparam int RD_LAT     = 2;
  localparam int PEND_W     = 2;

  // The countdown starts at WR_LAT-1 so the read three edges later sees zero.
  localparam logic [PEND_W-1:0] PEND_LOAD = PEND_W'(WR_LAT - 1);

  typedef enum logic {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] addr);
    return (addr == ZERO_REG);
  endfunction

endpackage

// File: rtl/regfile_access_ctrl_arbiter.sv
// Two-way round-robin arbiter for the shared register-file write port.
//   clk, rst_n     : clock, asynchronous active-low reset
//   req_a, req_b   : write requests (ALU, load unit)
//   accept         : a write was accepted this cycle (moves the pointer)
//   gnt_a, gnt_b   : combinational grants, forced low during reset
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic accept,
  output logic gnt_a,
  output logic gnt_b
);

  pri_e pri_q;
  pri_e pri_d;

  // Grant selection and pointer update.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    pri_d = pri_q;
    if (rst_n) begin
      gnt_a = req_a & (~req_b | (pri_q == PRI_A));
      gnt_b = req_b & (~req_a | (pri_q == PRI_B));
    end else begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
    end
    // Priority goes to the side that did not win.
    if (accept) begin
      pri_d = gnt_a ? PRI_B : PRI_A;
    end else begin
      pri_d = pri_q;
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pri_q <= PRI_A;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Access controller for the 32x64 register file: round-robin write-port
// sharing, per-register write-in-flight scoreboard gating reads, and a
// read-data-valid strobe aligned with the file's read latency.
//   Clk, Rst_n                   : clock, asynchronous active-low reset
//   WrReq*/WrAddr*/WrData*       : writeback requests (A = ALU, B = load)
//   WrGntA/WrGntB                : combinational write grants
//   RdReq, RdAddrA/RdAddrB       : read request and source registers
//   RdRdy                        : combinational read acceptance
//   RdValid                      : file buses hold the accepted read's data
//   RA/RB/RW/BusW/RegWr          : register file control and write data
module regfile_access_ctrl
  import regfile_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              WrReqA,
  input  logic [ADDR_W-1:0] WrAddrA,
  input  logic [DATA_W-1:0] WrDataA,
  input  logic              WrReqB,
  input  logic [ADDR_W-1:0] WrAddrB,
  input  logic [DATA_W-1:0] WrDataB,
  output logic              WrGntA,
  output logic              WrGntB,
  input  logic              RdReq,
  input  logic [ADDR_W-1:0] RdAddrA,
  input  logic [ADDR_W-1:0] RdAddrB,
  output logic              RdRdy,
  output logic              RdValid,
  output logic [ADDR_W-1:0] RA,
  output logic [ADDR_W-1:0] RB,
  output logic [ADDR_W-1:0] RW,
  output logic [DATA_W-1:0] BusW,
  output logic              RegWr
);

  logic [PEND_W-1:0] pend_q [NUM_REGS];
  logic [PEND_W-1:0] pend_d [NUM_REGS];
  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT-1:0] vld_d;
  logic              blk_a;
  logic              blk_b;
  logic              rd_acc;

  rr_arbiter2 u_arb (
    .clk    (Clk),
    .rst_n  (Rst_n),
    .req_a  (WrReqA),
    .req_b  (WrReqB),
    .accept (RegWr),
    .gnt_a  (WrGntA),
    .gnt_b  (WrGntB)
  );

  assign RA = RdAddrA;
  assign RB = RdAddrB;

  // Write-port mux: the granted side drives the file, otherwise all zero.
  always_comb begin
    RW    = '0;
    BusW  = '0;
    RegWr = 1'b0;
    if (WrGntA) begin
      RW    = WrAddrA;
      BusW  = WrDataA;
      RegWr = 1'b1;
    end else if (WrGntB) begin
      RW    = WrAddrB;
      BusW  = WrDataB;
      RegWr = 1'b1;
    end else begin
      RW    = '0;
      BusW  = '0;
      RegWr = 1'b0;
    end
  end

  // Scoreboard next state: reload on write, else count down to zero.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      pend_d[r] = '0;
      if (is_zero_reg(ADDR_W'(r))) begin
        pend_d[r] = '0;
      end else if (RegWr && (RW == ADDR_W'(r))) begin
        pend_d[r] = PEND_LOAD;
      end else if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end else begin
        pend_d[r] = '0;
      end
    end
  end

  // Read gating: the write granted this cycle counts as in flight already.
  always_comb begin
    blk_a = ~is_zero_reg(RdAddrA) &
            ((pend_q[RdAddrA] != '0) | (RegWr & (RW == RdAddrA)));
    blk_b = ~is_zero_reg(RdAddrB) &
            ((pend_q[RdAddrB] != '0) | (RegWr & (RW == RdAddrB)));
    RdRdy  = Rst_n & ~blk_a & ~blk_b;
    rd_acc = RdReq & RdRdy;
    vld_d  = {vld_q[RD_LAT-2:0], rd_acc};
  end

  assign RdValid = vld_q[RD_LAT-1];

  // Scoreboard and read-valid pipeline registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_q <= '{default: '0};
      vld_q  <= '0;
    end else begin
      pend_q <= pend_d;
      vld_q  <= vld_d;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Randomized + directed bench for regfile_access_ctrl with a register-file
// model attached and a queue-based scoreboard for read data.
module tb_regfile_access_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        WrReqA, WrReqB, RdReq;
  logic [4:0]  WrAddrA, WrAddrB, RdAddrA, RdAddrB;
  logic [63:0] WrDataA, WrDataB;
  logic        WrGntA, WrGntB, RdRdy, RdValid, RegWr;
  logic [4:0]  RA, RB, RW;
  logic [63:0] BusW;

  regfile_access_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .WrReqA(WrReqA), .WrAddrA(WrAddrA), .WrDataA(WrDataA),
    .WrReqB(WrReqB), .WrAddrB(WrAddrB), .WrDataB(WrDataB),
    .WrGntA(WrGntA), .WrGntB(WrGntB),
    .RdReq(RdReq), .RdAddrA(RdAddrA), .RdAddrB(RdAddrB),
    .RdRdy(RdRdy), .RdValid(RdValid),
    .RA(RA), .RB(RB), .RW(RW), .BusW(BusW), .RegWr(RegWr)
  );

  always #5 Clk = ~Clk;

  longint edge_idx = 0;
  always @(posedge Clk) edge_idx <= edge_idx + 1;

  // ---------------- register file model (environment) ----------------
  logic [63:0] mem [32];
  logic        wp_we [3];
  logic [4:0]  wp_a  [3];
  logic [63:0] wp_d  [3];
  logic [4:0]  ra_q = 5'd0, rb_q = 5'd0;
  logic [63:0] bus_a = 64'd0, bus_b = 64'd0;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 64'd0;
    for (int i = 0; i < 3; i++) begin wp_we[i] = 1'b0; wp_a[i] = 5'd0; wp_d[i] = 64'd0; end
  end

  always @(posedge Clk) begin
    wp_we[0] <= RegWr; wp_a[0] <= RW; wp_d[0] <= BusW;
    wp_we[1] <= wp_we[0]; wp_a[1] <= wp_a[0]; wp_d[1] <= wp_d[0];
    wp_we[2] <= wp_we[1]; wp_a[2] <= wp_a[1]; wp_d[2] <= wp_d[1];
    ra_q <= RA; rb_q <= RB;
    bus_a <= (ra_q == 5'd31) ? 64'd0 : mem[ra_q];
    bus_b <= (rb_q == 5'd31) ? 64'd0 : mem[rb_q];
  end

  always @(negedge Clk) begin
    if (wp_we[2] && wp_a[2] != 5'd31) mem[wp_a[2]] <= wp_d[2];
  end

  // ---------------- reference model ----------------
  typedef struct { longint due; logic [63:0] a; logic [63:0] b; } rd_exp_t;
  rd_exp_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          pri_b = 1'b0;          // 1: side B has priority
  longint      last_wr [32];          // edge at which register was last written
  logic [63:0] ref_mem [32];          // architectural contents
  logic        last_rdy;

  initial begin
    for (int i = 0; i < 32; i++) begin last_wr[i] = -100; ref_mem[i] = 64'd0; end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_idx);
    end
  endtask

  function automatic bit rd_ok(input logic [4:0] a, input longint up, input bit ew, input logic [4:0] erw);
    if (a == 5'd31) return 1'b1;
    if (ew && erw == a) return 1'b0;
    return (up - last_wr[a]) >= 3;
  endfunction

  // One clock: predict, compare combinational outputs, advance model.
  task automatic cycle();
    bit ga, gb, ew, er;
    logic [4:0] erw;
    logic [63:0] ebw;
    longint up;
    rd_exp_t e;
    up = edge_idx + 1;
    ga = 1'b0; gb = 1'b0; ew = 1'b0; er = 1'b0; erw = 5'd0; ebw = 64'd0;
    if (!Rst_n) begin
      exp_q.delete();
    end else begin
      ga = WrReqA && (!WrReqB || !pri_b);
      gb = WrReqB && (!WrReqA || pri_b);
      ew = ga || gb;
      if (ga) begin erw = WrAddrA; ebw = WrDataA; end
      else if (gb) begin erw = WrAddrB; ebw = WrDataB; end
      er = rd_ok(RdAddrA, up, ew, erw) && rd_ok(RdAddrB, up, ew, erw);
    end
    #1;
    last_rdy = RdRdy;
    chk("gnt_a", {63'd0, WrGntA}, {63'd0, ga});
    chk("gnt_b", {63'd0, WrGntB}, {63'd0, gb});
    chk("reg_wr", {63'd0, RegWr}, {63'd0, ew});
    chk("rw", {59'd0, RW}, {59'd0, erw});
    chk("bus_w", BusW, ebw);
    chk("rd_rdy", {63'd0, RdRdy}, {63'd0, er});
    chk("ra_rb", {54'd0, RA, RB}, {54'd0, RdAddrA, RdAddrB});
    @(posedge Clk);
    if (!Rst_n) begin
      pri_b = 1'b0;
      for (int i = 0; i < 32; i++) last_wr[i] = -100;
    end else begin
      if (ew) begin
        pri_b = ga;
        last_wr[erw] = up;
        if (erw != 5'd31) ref_mem[erw] = ebw;
      end
      if (RdReq && er) begin
        e.due = up + 1;
        e.a = ref_mem[RdAddrA];
        e.b = ref_mem[RdAddrB];
        exp_q.push_back(e);
      end
    end
    @(negedge Clk);
  endtask

  // Scoreboard monitor: pops an expectation whenever RdValid is presented.
  always @(negedge Clk) begin
    rd_exp_t e;
    #2;
    if (RdValid) begin
      if (exp_q.size() == 0) begin
        chk("rd_valid_spurious", 64'd1, 64'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_valid_time", edge_idx, e.due);
        chk("bus_a", bus_a, e.a);
        chk("bus_b", bus_b, e.b);
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_idx) begin
      e = exp_q.pop_front();
      chk("rd_valid_missing", 64'd0, 64'd1);
    end
  end

  task automatic idle(input int n);
    WrReqA = 1'b0; WrReqB = 1'b0; RdReq = 1'b0;
    RdAddrA = 5'd31; RdAddrB = 5'd31;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit exp_raw [4];
    bit exp_rew [5];
    exp_raw = '{1'b0, 1'b0, 1'b0, 1'b1};
    exp_rew = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset with requests driven.
    Rst_n = 1'b0;
    WrReqA = 1'b1; WrAddrA = 5'd4; WrDataA = 64'h11;
    WrReqB = 1'b1; WrAddrB = 5'd6; WrDataB = 64'h22;
    RdReq = 1'b1; RdAddrA = 5'd1; RdAddrB = 5'd2;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_rd_valid", {63'd0, RdValid}, 64'd0);
    end
    Rst_n = 1'b1;
    idle(1);
    chk("post_rst_rdy", {63'd0, last_rdy}, 64'd1);

    // Arbitration: both requesting for four cycles.
    WrReqA = 1'b1; WrAddrA = 5'd1; WrDataA = 64'hA0;
    WrReqB = 1'b1; WrAddrB = 5'd2; WrDataB = 64'hB0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("arb_rw_seq", {59'd0, RW}, (i % 2 == 0) ? 64'd1 : 64'd2);
      cycle();
    end
    idle(4);

    // RAW stall on r5.
    WrReqA = 1'b1; WrAddrA = 5'd5; WrDataA = 64'hDEAD;
    RdReq = 1'b1; RdAddrA = 5'd5; RdAddrB = 5'd31;
    for (int i = 0; i < 4; i++) begin
      cycle();
      WrReqA = 1'b0;
      chk("raw_rdy_seq", {63'd0, last_rdy}, {63'd0, exp_raw[i]});
    end
    idle(4);

    // Zero register: write and read r31 in the same cycle.
    WrReqB = 1'b1; WrAddrB = 5'd31; WrDataB = 64'hFF;
    RdReq = 1'b1; RdAddrA = 5'd31; RdAddrB = 5'd31;
    cycle();
    chk("zero_reg_rdy", {63'd0, last_rdy}, 64'd1);
    idle(4);

    // Re-write extends the stall on r7.
    WrReqA = 1'b1; WrAddrA = 5'd7; WrDataA = 64'h70;
    RdReq = 1'b1; RdAddrA = 5'd7; RdAddrB = 5'd31;
    for (int i = 0; i < 5; i++) begin
      cycle();
      WrDataA = 64'h71;
      if (i >= 1) WrReqA = 1'b0;
      chk("rewrite_rdy_seq", {63'd0, last_rdy}, {63'd0, exp_rew[i]});
    end
    idle(4);

    // Reset mid-flight: write r3, then reset for three edges.
    WrReqA = 1'b1; WrAddrA = 5'd3; WrDataA = 64'h3333_CAFE;
    cycle();
    Rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_mid_regwr", {63'd0, RegWr}, 64'd0);
    end
    Rst_n = 1'b1;
    WrReqA = 1'b0;
    RdReq = 1'b1; RdAddrA = 5'd3; RdAddrB = 5'd31;
    cycle();
    chk("rst_mid_rdy", {63'd0, last_rdy}, 64'd1);
    idle(4);

    // Randomized traffic, with occasional three-edge resets.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        Rst_n = 1'b0;
        for (int k = 0; k < 3; k++) cycle();
        Rst_n = 1'b1;
      end
      WrReqA = $urandom_range(0, 1) == 1;
      WrReqB = $urandom_range(0, 1) == 1;
      WrAddrA = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      WrAddrB = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      WrDataA = {$urandom, $urandom};
      WrDataB = {$urandom, $urandom};
      RdReq = $urandom_range(0, 3) != 0;
      RdAddrA = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      RdAddrB = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      cycle();
    end
    idle(6);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
